// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: operand/destination addresses, pipeline stall/flush controls and
// the data-memory req/ack handshake with its sticky timeout flag.
interface hazard_ctrl_if #(
    parameter int AW = 5
);
    logic [AW-1:0] ad1d, ad2d, ad1e, ad2e, rde, rdm, rdw;
    logic          regWrtm, regWrtw, ldE, pcSrce, memReqm, memAckm;
    logic [1:0]    fwdAe, fwdBe;
    logic          stallf, stalld, stalle, stallm;
    logic          flushd, flushe, flushw;
    logic          memErr;

    modport master (
        output ad1d, ad2d, ad1e, ad2e, rde, rdm, rdw,
        output regWrtm, regWrtw, ldE, pcSrce, memReqm, memAckm,
        input  fwdAe, fwdBe, stallf, stalld, stalle, stallm,
        input  flushd, flushe, flushw, memErr
    );

    modport slave (
        input  ad1d, ad2d, ad1e, ad2e, rde, rdm, rdw,
        input  regWrtm, regWrtw, ldE, pcSrce, memReqm, memAckm,
        output fwdAe, fwdBe, stallf, stalld, stalle, stallm,
        output flushd, flushe, flushw, memErr
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage in-order core: EX forwarding, load-use/branch stall and flush,
// and a RUN/MWAIT sequencer with timeout for data memory. HAZARD_PERF_EN adds saturating counters.
module hazard_ctrl #(
    parameter int AW    = 5,
    parameter int TMO_W = 8
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] luCnt,
    output logic [CNT_W-1:0] flCnt,
    output logic [CNT_W-1:0] mwCnt
`endif
);

    typedef enum logic {RUN, MWAIT} state_t;

    // Last timer value before the watchdog fires (2**TMO_W-2); the next miss makes 2**TMO_W-1.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t           state, state_nxt;
    logic [TMO_W-1:0] timer, timer_nxt;
    logic             err, err_nxt;
    logic             mem_wait, lu, ctl_flush, lu_stall;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                           input logic          wm,
                                           input logic [AW-1:0] rm,
                                           input logic          ww,
                                           input logic [AW-1:0] rw);
        logic [1:0] sel;
        sel = 2'b00;
        if (wm && rm != '0 && rm == src)
            sel = 2'b10;
        else if (ww && rw != '0 && rw == src)
            sel = 2'b01;
        return sel;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            timer <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        err_nxt   = err;
        mem_wait  = 1'b0;
        case (state)
            RUN: begin
                if (hz.memReqm && !hz.memAckm) begin
                    state_nxt = MWAIT;
                    timer_nxt = '0;
                    mem_wait  = 1'b1;
                end
            end
            MWAIT: begin
                mem_wait = 1'b1;
                if (hz.memAckm) begin
                    state_nxt = RUN;
                end else if (timer == TMO_LAST) begin
                    state_nxt = RUN;
                    err_nxt   = 1'b1;
                    timer_nxt = timer + 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Priority: memory wait, then control flush, then load-use.
    always_comb begin
        lu        = hz.ldE && (hz.rde != '0) && ((hz.rde == hz.ad1d) || (hz.rde == hz.ad2d));
        ctl_flush = !mem_wait && hz.pcSrce;
        lu_stall  = !mem_wait && !hz.pcSrce && lu;

        hz.fwdAe  = fwd_sel(hz.ad1e, hz.regWrtm, hz.rdm, hz.regWrtw, hz.rdw);
        hz.fwdBe  = fwd_sel(hz.ad2e, hz.regWrtm, hz.rdm, hz.regWrtw, hz.rdw);
        hz.stallf = mem_wait || lu_stall;
        hz.stalld = mem_wait || lu_stall;
        hz.stalle = mem_wait;
        hz.stallm = mem_wait;
        hz.flushd = ctl_flush;
        hz.flushe = ctl_flush || lu_stall;
        hz.flushw = mem_wait;
        hz.memErr = err;

        // While reset is held, bubble every register and forward nothing.
        if (!rst_n) begin
            hz.fwdAe  = 2'b00;
            hz.fwdBe  = 2'b00;
            hz.stallf = 1'b0;
            hz.stalld = 1'b0;
            hz.stalle = 1'b0;
            hz.stallm = 1'b0;
            hz.flushd = 1'b1;
            hz.flushe = 1'b1;
            hz.flushw = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luCnt <= '0;
            flCnt <= '0;
            mwCnt <= '0;
        end else begin
            if (lu_stall && luCnt != '1)
                luCnt <= luCnt + 1'b1;
            if (ctl_flush && flCnt != '1)
                flCnt <= flCnt + 1'b1;
            if (mem_wait && mwCnt != '1)
                mwCnt <= mwCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TMO_W=4): forwarding, load-use, branch flush, memory wait,
// timeout and reset during a wait.
module tb_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    hazard_ctrl_if #(.AW(5)) bus ();

`ifdef HAZARD_PERF_EN
    logic [31:0] luCnt, flCnt, mwCnt;
`endif

    hazard_ctrl #(.AW(5), .TMO_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus.slave)
`ifdef HAZARD_PERF_EN
        ,
        .luCnt (luCnt),
        .flCnt (flCnt),
        .mwCnt (mwCnt)
`endif
    );

    // {stallf, stalld, stalle, stallm, flushd, flushe, flushw}
    logic [6:0] ctl;
    assign ctl = {bus.stallf, bus.stalld, bus.stalle, bus.stallm, bus.flushd, bus.flushe, bus.flushw};

    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_RST  = 7'b0000111;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_PC   = 7'b0000110;
    localparam logic [6:0] C_MEM  = 7'b1111001;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_in();
        bus.ad1d = '0; bus.ad2d = '0; bus.ad1e = '0; bus.ad2e = '0;
        bus.rde = '0;  bus.rdm = '0;  bus.rdw = '0;
        bus.regWrtm = 1'b0; bus.regWrtw = 1'b0; bus.ldE = 1'b0; bus.pcSrce = 1'b0;
        bus.memReqm = 1'b0; bus.memAckm = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        clr_in();

        // Reset state: outputs forced even with a forwarding match present
        bus.regWrtm = 1'b1; bus.rdm = 5'd5; bus.ad1e = 5'd5;
        #2;
        chk("rst_ctl", 32'(ctl), 32'(C_RST));
        chk("rst_fwd", 32'({bus.fwdAe, bus.fwdBe}), 32'h0);
        chk("rst_err", 32'(bus.memErr), 32'h0);
`ifdef HAZARD_PERF_EN
        chk("rst_cnt", luCnt | flCnt | mwCnt, 32'h0);
`endif
        clr_in();
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        chk("post_rst_ctl", 32'(ctl), 32'(C_IDLE));

        // Forwarding
        bus.rdm = 5'd5; bus.regWrtm = 1'b1; bus.ad1e = 5'd5; bus.rdw = 5'd5; bus.regWrtw = 1'b1;
        settle();
        chk("fwdA_mem_wins", 32'(bus.fwdAe), 32'h2);
        chk("fwdB_none", 32'(bus.fwdBe), 32'h0);
        bus.regWrtm = 1'b0;
        settle();
        chk("fwdA_wb", 32'(bus.fwdAe), 32'h1);
        bus.ad1e = 5'd0;
        settle();
        chk("fwdA_x0_reg", 32'(bus.fwdAe), 32'h0);
        bus.ad2e = 5'd5;
        settle();
        chk("fwdB_wb", 32'(bus.fwdBe), 32'h1);
        bus.regWrtm = 1'b1; bus.rdm = 5'd5; bus.rdw = 5'd9;
        settle();
        chk("fwdB_mem", 32'(bus.fwdBe), 32'h2);
        bus.rdm = 5'd0; bus.regWrtw = 1'b1; bus.rdw = 5'd0; bus.ad1e = 5'd0; bus.ad2e = 5'd0;
        settle();
        chk("fwd_x0_never", 32'({bus.fwdAe, bus.fwdBe}), 32'h0);
        chk("fwd_ctl_idle", 32'(ctl), 32'(C_IDLE));
        clr_in();

        // Load-use
        tick();
        bus.ldE = 1'b1; bus.rde = 5'd7; bus.ad2d = 5'd7;
        settle();
        chk("lu_stall", 32'(ctl), 32'(C_LU));
        tick();
        bus.ldE = 1'b0;
        settle();
        chk("lu_release", 32'(ctl), 32'(C_IDLE));
        bus.ldE = 1'b1; bus.rde = 5'd0; bus.ad1d = 5'd0; bus.ad2d = 5'd0;
        settle();
        chk("lu_x0_ignored", 32'(ctl), 32'(C_IDLE));
        clr_in();

        // Branch overrides load-use
        tick();
        bus.ldE = 1'b1; bus.rde = 5'd7; bus.ad1d = 5'd7; bus.pcSrce = 1'b1;
        settle();
        chk("pc_over_lu", 32'(ctl), 32'(C_PC));
        tick();
        clr_in();
        settle();
        chk("pc_release", 32'(ctl), 32'(C_IDLE));

        // Memory wait with ack on the fourth cycle
        bus.memReqm = 1'b1;
        settle();
        chk("mw_entry", 32'(ctl), 32'(C_MEM));
        tick();
        bus.pcSrce = 1'b1; bus.ldE = 1'b1; bus.rde = 5'd7; bus.ad1d = 5'd7;
        settle();
        chk("mw_ignore_pc_lu", 32'(ctl), 32'(C_MEM));
        tick();
        bus.pcSrce = 1'b0; bus.ldE = 1'b0;
        bus.regWrtm = 1'b1; bus.rdm = 5'd3; bus.ad1e = 5'd3;
        settle();
        chk("mw_fwd_live", 32'(bus.fwdAe), 32'h2);
        chk("mw_cycle2", 32'(ctl), 32'(C_MEM));
        tick();
        bus.memAckm = 1'b1;
        settle();
        chk("mw_ack_cycle", 32'(ctl), 32'(C_MEM));
        tick();
        clr_in();
        settle();
        chk("mw_release", 32'(ctl), 32'(C_IDLE));

        // Zero-wait access and stray ack
        bus.memReqm = 1'b1; bus.memAckm = 1'b1;
        settle();
        chk("zw_no_stall", 32'(ctl), 32'(C_IDLE));
        tick();
        bus.memReqm = 1'b0;
        settle();
        chk("zw_stay_run", 32'(ctl), 32'(C_IDLE));
        tick();
        bus.memAckm = 1'b0;
        settle();
        chk("stray_ack", 32'({bus.memErr, ctl}), 32'h0);

        // Timeout: 15 MWAIT cycles without ack
        bus.memReqm = 1'b1;
        settle();
        chk("tmo_entry", 32'({bus.memErr, ctl}), 32'({1'b0, C_MEM}));
        tick();
        for (int i = 0; i < 15; i++) begin
            settle();
            chk($sformatf("tmo_wait%0d", i), 32'({bus.memErr, ctl}), 32'({1'b0, C_MEM}));
            tick();
        end
        bus.memReqm = 1'b0;
        settle();
        chk("tmo_err_run", 32'({bus.memErr, ctl}), 32'({1'b1, C_IDLE}));
        tick();
        tick();
        chk("tmo_err_sticky", 32'(bus.memErr), 32'h1);

        // Reset in the middle of a wait
        bus.memReqm = 1'b1;
        tick();
        tick();
        chk("rst_mid_pre", 32'(ctl), 32'(C_MEM));
        rst_n = 1'b0;
        settle();
        chk("rst_mid_ctl", 32'({bus.memErr, ctl}), 32'({1'b0, C_RST}));
`ifdef HAZARD_PERF_EN
        chk("rst_mid_cnt", luCnt | flCnt | mwCnt, 32'h0);
`endif
        bus.memReqm = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        chk("rst_mid_run", 32'({bus.memErr, ctl}), 32'({1'b0, C_IDLE}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
